wb_shared_arbiter: RTL and testbench
====================================

Name: wb_shared_arbiter

Overview:
- Shares one Wishbone slave-side bus between the two processor masters: master 0 = instruction bus, master 1 = data bus.
- Decodes the granted master's address to one of NUM_SLAVES slave selects (boot ROM, RAM, LED, 7-seg, switches, buttons, I2C0).
- Round-robin arbitration; grant is held for the whole CYC.
- Generates an error response for unmapped addresses and for slaves that do not answer within the watchdog limit.

Parameters:
- NUM_SLAVES, 7, number of slave selects.
- ADDR_W, 32, address width.
- DATA_W, 32, data width; SEL_W = DATA_W/8.
- TIMEOUT, 255, maximum cycles STB may wait for ACK/ERR; counter width = $clog2(TIMEOUT+1).
- SLAVE_BASE, {NUM_SLAVES x ADDR_W}, per-slave base address (package defaults).
- SLAVE_MASK, {NUM_SLAVES x ADDR_W}, per-slave compare mask; slave k hits when (adr & MASK[k]) == BASE[k].

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- m_cyc_i  in  2  master CYC, bit 0 = IBus, bit 1 = DBus.
- m_stb_i  in  2  master STB.
- m_we_i  in  2  master WE.
- m_adr_i  in  2*ADDR_W  master addresses.
- m_dat_i  in  2*DATA_W  master write data.
- m_sel_i  in  2*SEL_W  master byte selects.
- m_dat_o  out  DATA_W  read data, shared by both masters.
- m_ack_o  out  2  per-master ACK.
- m_err_o  out  2  per-master ERR.
- s_cyc_o  out  1  slave-side CYC.
- s_stb_o  out  NUM_SLAVES  one-hot slave STB.
- s_we_o  out  1  slave WE.
- s_adr_o  out  ADDR_W  slave address.
- s_dat_o  out  DATA_W  slave write data.
- s_sel_o  out  SEL_W  slave byte selects.
- s_dat_i  in  NUM_SLAVES*DATA_W  slave read data.
- s_ack_i  in  NUM_SLAVES  slave ACK.
- s_err_i  in  NUM_SLAVES  slave ERR.
- busy_o  out  1  a grant is active.
- grant_o  out  2  one-hot current owner.

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE, grant=00, priority pointer=0 (IBus first), timeout count=0.
- All outputs are 0 during reset: s_cyc_o, s_stb_o, m_ack_o, m_err_o, busy_o, grant_o. Data/address outputs are 0.
- States:
  - IDLE: no grant.
  - OWN: bus driven by owner.
  - ERRRESP: one-cycle error to owner.
  - GAP: one mandatory idle cycle after release.
- IDLE transitions:
  - Any m_cyc_i high -> OWN with grant registered; latency is 1 cycle from request to grant.
  - Both requesting -> master indicated by the pointer wins.
- OWN datapath:
  - s_cyc_o = owner CYC.
  - s_adr/dat/sel/we muxed combinationally from the owner.
  - s_stb_o[k] = owner STB & hit[k]; lowest k wins if several regions hit.
- OWN response path:
  - m_ack_o[owner] = |(s_ack_i & s_stb_o), combinational, same cycle.
  - m_err_o[owner] = |(s_err_i & s_stb_o), combinational, same cycle.
  - m_dat_o = s_dat_i of the selected slave; 0 when no slave is selected.
  - The non-owner always sees ack=err=0.
- Decode miss: owner STB high with no hit -> s_stb_o=0 -> ERRRESP next cycle. m_err_o[owner]=1 for exactly one cycle, then back to OWN.
- Watchdog:
  - Counter increments each OWN cycle with owner STB high and no ACK/ERR.
  - Clears on ACK, ERR, or STB low.
  - count == TIMEOUT -> ERRRESP: s_stb_o forced 0, owner gets one-cycle ERR, counter cleared.
- Release: owner CYC low in OWN -> s_cyc_o/s_stb_o drop the same cycle (combinational gating).
  - Next state GAP; pointer := other master.
  - GAP -> IDLE after one cycle; nothing is granted in GAP.
- Slave ACK/ERR arriving in ERRRESP, GAP or IDLE is ignored and never forwarded.
- Owner dropping CYC during ERRRESP: the err is still issued, then GAP.
- Block cycles (CYC held across multiple STB) keep the grant; the other master waits regardless of its priority.
- Reset mid-transaction: all outputs clear immediately; no ack is emitted.

Decomposition:
- Package wb_bus_pkg:
  - ADDR_W/DATA_W constants.
  - Slave index enum (SLV_BOOTROM=0, SLV_RAM, SLV_LED, SLV_SEG7, SLV_SWTCH, SLV_BTTN, SLV_I2C0).
  - Default base/mask arrays (e.g. bootrom 0x0000_0000/0xFFFF_F000, RAM 0x1000_0000/0xFFFF_0000, peripherals 0x8000_0n00/0xFFFF_FF00).
  - Arbiter state enum.
- Sub-module wb_addr_decode: purely combinational, adr -> one-hot hit vector plus a miss flag.

Test Plan:
- IBus alone reads 0x1000_0004 with RAM acking after 2 cycles -> s_stb_o=0000010; m_ack_o=01 exactly one cycle; m_dat_o equals RAM data; DBus sees no ack.
- Both masters raise CYC in the same cycle after reset -> IBus granted first. After IBus drops CYC there is one GAP cycle, then DBus is granted (grant_o=10). The next simultaneous request grants IBus.
- DBus writes 0xF000_0000 (unmapped) -> no s_stb_o bit; m_err_o=10 for one cycle, two cycles after STB; grant retained.
- TIMEOUT=4, LED slave never acks -> after 4 STB cycles, s_stb_o drops; m_err_o for one cycle; counter restarts on the next access.
- DBus holds CYC across 3 STB accesses while IBus requests -> all 3 complete before IBus is granted.
- Reset pulled low while RAM access is pending -> all outputs 0 asynchronously; a late s_ack_i after reset release is not forwarded.

Source files
------------

// File: rtl/wb_shared_arbiter_pkg.sv
// Shared Wishbone bus definitions: widths, slave map and arbiter states.
package wb_bus_pkg;

  localparam int unsigned WB_ADDR_W     = 32;
  localparam int unsigned WB_DATA_W     = 32;
  localparam int unsigned WB_NUM_SLAVES = 7;

  // Slave select index, matching bit positions of s_stb_o.
  typedef enum logic [2:0] {
    SLV_BOOTROM = 3'd0,
    SLV_RAM     = 3'd1,
    SLV_LED     = 3'd2,
    SLV_SEG7    = 3'd3,
    SLV_SWTCH   = 3'd4,
    SLV_BTTN    = 3'd5,
    SLV_I2C0    = 3'd6
  } slave_idx_e;

  // Arbiter sequencing.
  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_OWN     = 2'd1,
    ARB_ERRRESP = 2'd2,
    ARB_GAP     = 2'd3
  } arb_state_e;

  // Default address map, slave 0 in the least significant word.
  localparam logic [WB_NUM_SLAVES*WB_ADDR_W-1:0] WB_DEFAULT_BASE = {
    32'h8000_0500,  // I2C0
    32'h8000_0400,  // buttons
    32'h8000_0300,  // switches
    32'h8000_0200,  // 7-seg
    32'h8000_0100,  // LED
    32'h1000_0000,  // RAM
    32'h0000_0000   // boot ROM
  };

  localparam logic [WB_NUM_SLAVES*WB_ADDR_W-1:0] WB_DEFAULT_MASK = {
    32'hFFFF_FF00,
    32'hFFFF_FF00,
    32'hFFFF_FF00,
    32'hFFFF_FF00,
    32'hFFFF_FF00,
    32'hFFFF_0000,
    32'hFFFF_F000
  };

endpackage

// File: rtl/wb_shared_arbiter_if.sv
// Bus bundle between the two processor masters, the arbiter and the slaves.
// The slave modport is the arbiter's view; the master modport is the
// surrounding system's view.
interface wb_shared_arbiter_if #(
  parameter int unsigned NUM_SLAVES = 7,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32
);
  localparam int unsigned SEL_W = DATA_W / 8;

  // Master side (bit/slice 0 = IBus, 1 = DBus)
  logic [1:0]              m_cyc_i;
  logic [1:0]              m_stb_i;
  logic [1:0]              m_we_i;
  logic [2*ADDR_W-1:0]     m_adr_i;
  logic [2*DATA_W-1:0]     m_dat_i;
  logic [2*SEL_W-1:0]      m_sel_i;
  logic [DATA_W-1:0]       m_dat_o;
  logic [1:0]              m_ack_o;
  logic [1:0]              m_err_o;

  // Slave side
  logic                    s_cyc_o;
  logic [NUM_SLAVES-1:0]   s_stb_o;
  logic                    s_we_o;
  logic [ADDR_W-1:0]       s_adr_o;
  logic [DATA_W-1:0]       s_dat_o;
  logic [SEL_W-1:0]        s_sel_o;
  logic [NUM_SLAVES*DATA_W-1:0] s_dat_i;
  logic [NUM_SLAVES-1:0]   s_ack_i;
  logic [NUM_SLAVES-1:0]   s_err_i;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
    output m_dat_o, m_ack_o, m_err_o,
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
    input  s_dat_i, s_ack_i, s_err_i
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
    input  m_dat_o, m_ack_o, m_err_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
    output s_dat_i, s_ack_i, s_err_i
  );

endinterface

// File: rtl/wb_shared_arbiter_addr_decode.sv
// Combinational address decoder: one-hot hit (lowest region wins) plus miss.
module wb_addr_decode #(
  parameter int unsigned                NUM_SLAVES = 7,
  parameter int unsigned                ADDR_W     = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] BASE     = '0,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] MASK     = '0
) (
  input  logic [ADDR_W-1:0]     adr,
  output logic [NUM_SLAVES-1:0] hit,
  output logic                  miss
);

  logic found;

  // Scan regions in ascending order; the first match claims the select.
  always_comb begin
    hit   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      if (!found &&
          ((adr & MASK[k*ADDR_W +: ADDR_W]) == BASE[k*ADDR_W +: ADDR_W])) begin
        hit[k] = 1'b1;
        found  = 1'b1;
      end
    end
    miss = !found;
  end

endmodule

// File: rtl/wb_shared_arbiter.sv
// Two-master Wishbone arbiter with address decode, round-robin grant held
// for the whole CYC, decode-miss and watchdog error responses.
module wb_shared_arbiter
  import wb_bus_pkg::*;
#(
  parameter int unsigned                  NUM_SLAVES = WB_NUM_SLAVES,
  parameter int unsigned                  ADDR_W     = WB_ADDR_W,
  parameter int unsigned                  DATA_W     = WB_DATA_W,
  parameter int unsigned                  TIMEOUT    = 255,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = WB_DEFAULT_BASE,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = WB_DEFAULT_MASK
) (
  input  logic               clock,
  input  logic               reset,
  wb_shared_arbiter_if.slave bus,
  output logic               busy_o,
  output logic [1:0]         grant_o
);

  localparam int unsigned SEL_W = DATA_W / 8;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  arb_state_e             state;
  logic [1:0]             grant;
  logic                   ptr;       // 0: IBus preferred, 1: DBus preferred
  logic [CNT_W-1:0]       wd_cnt;

  logic                   own_cyc;
  logic                   own_stb;
  logic                   own_we;
  logic [ADDR_W-1:0]      own_adr;
  logic [DATA_W-1:0]      own_dat;
  logic [SEL_W-1:0]       own_sel;

  logic [NUM_SLAVES-1:0]  hit;
  logic                   miss;
  logic [NUM_SLAVES-1:0]  stb_vec;
  logic                   any_ack;
  logic                   any_err;
  logic                   timed_out;
  logic [DATA_W-1:0]      rdata;

  // Owner mux: everything reads as zero while nobody holds the grant.
  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_adr = '0;
    own_dat = '0;
    own_sel = '0;
    if (grant[0]) begin
      own_cyc = bus.m_cyc_i[0];
      own_stb = bus.m_stb_i[0];
      own_we  = bus.m_we_i[0];
      own_adr = bus.m_adr_i[0 +: ADDR_W];
      own_dat = bus.m_dat_i[0 +: DATA_W];
      own_sel = bus.m_sel_i[0 +: SEL_W];
    end else if (grant[1]) begin
      own_cyc = bus.m_cyc_i[1];
      own_stb = bus.m_stb_i[1];
      own_we  = bus.m_we_i[1];
      own_adr = bus.m_adr_i[ADDR_W +: ADDR_W];
      own_dat = bus.m_dat_i[DATA_W +: DATA_W];
      own_sel = bus.m_sel_i[SEL_W +: SEL_W];
    end
  end

  wb_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_W     (ADDR_W),
    .BASE       (SLAVE_BASE),
    .MASK       (SLAVE_MASK)
  ) u_decode (
    .adr  (own_adr),
    .hit  (hit),
    .miss (miss)
  );

  // Slave strobe and response gathering; only live in OWN, and suppressed
  // on the cycle the watchdog expires.
  always_comb begin
    timed_out = (wd_cnt == CNT_W'(TIMEOUT));
    stb_vec   = '0;
    if (state == ARB_OWN && own_cyc && own_stb && !timed_out) begin
      stb_vec = hit;
    end
    any_ack = |(bus.s_ack_i & stb_vec);
    any_err = |(bus.s_err_i & stb_vec);
    rdata   = '0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      if (stb_vec[k]) begin
        rdata = bus.s_dat_i[k*DATA_W +: DATA_W];
      end
    end
  end

  assign bus.s_cyc_o = own_cyc;
  assign bus.s_stb_o = stb_vec;
  assign bus.s_we_o  = own_we;
  assign bus.s_adr_o = own_adr;
  assign bus.s_dat_o = own_dat;
  assign bus.s_sel_o = own_sel;

  assign bus.m_dat_o = rdata;
  assign bus.m_ack_o = any_ack ? grant : 2'b00;
  assign bus.m_err_o = (any_err || state == ARB_ERRRESP) ? grant : 2'b00;

  assign grant_o = grant;
  assign busy_o  = |grant;

  // Arbiter FSM with registered grant, priority pointer and watchdog.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= ARB_IDLE;
      grant  <= 2'b00;
      ptr    <= 1'b0;
      wd_cnt <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          wd_cnt <= '0;
          if (bus.m_cyc_i[0] && (!bus.m_cyc_i[1] || !ptr)) begin
            grant <= 2'b01;
            state <= ARB_OWN;
          end else if (bus.m_cyc_i[1]) begin
            grant <= 2'b10;
            state <= ARB_OWN;
          end
        end
        ARB_OWN: begin
          if (!own_cyc) begin
            state  <= ARB_GAP;
            grant  <= 2'b00;
            ptr    <= ~grant[1];
            wd_cnt <= '0;
          end else if (timed_out || (own_stb && miss)) begin
            state  <= ARB_ERRRESP;
            wd_cnt <= '0;
          end else if (!own_stb || any_ack || any_err) begin
            wd_cnt <= '0;
          end else begin
            wd_cnt <= wd_cnt + CNT_W'(1);
          end
        end
        ARB_ERRRESP: begin
          wd_cnt <= '0;
          if (!own_cyc) begin
            state <= ARB_GAP;
            grant <= 2'b00;
            ptr   <= ~grant[1];
          end else begin
            state <= ARB_OWN;
          end
        end
        ARB_GAP: begin
          state <= ARB_IDLE;
        end
        default: begin
          state <= ARB_IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_shared_arbiter.sv
// Directed bench for wb_shared_arbiter with a response scoreboard.
module tb_wb_shared_arbiter;

  localparam logic [6:0] STB_RAM = 7'b0000010;
  localparam logic [6:0] STB_LED = 7'b0000100;

  typedef struct {
    logic [1:0]  ack;
    logic [1:0]  err;
    logic [31:0] data;
  } resp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       busy;
  logic [1:0] grant;

  int unsigned checks = 0;
  int unsigned errors = 0;
  resp_t       sb[$];

  wb_shared_arbiter_if #(.NUM_SLAVES(7), .ADDR_W(32), .DATA_W(32)) bus ();

  wb_shared_arbiter #(
    .NUM_SLAVES (7),
    .ADDR_W     (32),
    .DATA_W     (32),
    .TIMEOUT    (4)
  ) dut (
    .clock   (clk),
    .reset   (rst_n),
    .bus     (bus),
    .busy_o  (busy),
    .grant_o (grant)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] ack, input logic [1:0] err, input logic [31:0] data);
    resp_t r;
    r.ack  = ack;
    r.err  = err;
    r.data = data;
    sb.push_back(r);
  endtask

  task automatic expect_resp(input string tag);
    resp_t r;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed=response expected=empty scoreboard", tag);
    end else begin
      r = sb.pop_front();
      check({tag, "_ack"}, 64'(bus.m_ack_o), 64'(r.ack));
      check({tag, "_err"}, 64'(bus.m_err_o), 64'(r.err));
      if (r.ack != 2'b00) check({tag, "_data"}, 64'(bus.m_dat_o), 64'(r.data));
    end
  endtask

  task automatic drive_m(input int m, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat);
    bus.m_cyc_i[m]         = cyc;
    bus.m_stb_i[m]         = stb;
    bus.m_we_i[m]          = we;
    bus.m_adr_i[m*32 +: 32] = adr;
    bus.m_dat_i[m*32 +: 32] = dat;
    bus.m_sel_i[m*4 +: 4]   = 4'hF;
  endtask

  task automatic slave_resp(input int k, input logic ack, input logic [31:0] d);
    bus.s_ack_i[k]          = ack;
    bus.s_dat_i[k*32 +: 32] = d;
  endtask

  // Counts consecutive negedge samples with a slave strobe active.
  task automatic timeout_probe(input string tag);
    int unsigned n = 0;
    bit started = 0;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (bus.s_stb_o != 7'b0) begin
        started = 1;
        n++;
        if (n == 1) check({tag, "_stb"}, 64'(bus.s_stb_o), 64'(STB_LED));
      end else if (started) begin
        break;
      end
      @(negedge clk);
    end
    check({tag, "_len"}, 64'(n), 64'd4);
    check({tag, "_noerr_yet"}, 64'(bus.m_err_o), 64'd0);
    @(negedge clk); #1;
    expect_resp({tag, "_err"});
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.m_cyc_i = '0;
    bus.m_stb_i = '0;
    bus.m_we_i  = '0;
    bus.m_adr_i = '0;
    bus.m_dat_i = '0;
    bus.m_sel_i = '0;
    bus.s_dat_i = '0;
    bus.s_ack_i = '0;
    bus.s_err_i = '0;

    // Reset holds everything low even with requests and acks present.
    drive_m(0, 1, 1, 0, 32'h1000_0004, 32'h0);
    drive_m(1, 1, 1, 1, 32'h1000_0008, 32'h55);
    bus.s_ack_i = '1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_cyc", 64'(bus.s_cyc_o), 64'd0);
    check("rst_stb", 64'(bus.s_stb_o), 64'd0);
    check("rst_ack", 64'(bus.m_ack_o), 64'd0);
    check("rst_err", 64'(bus.m_err_o), 64'd0);
    check("rst_adr", 64'(bus.s_adr_o), 64'd0);
    drive_m(0, 0, 0, 0, 32'h0, 32'h0);
    drive_m(1, 0, 0, 0, 32'h0, 32'h0);
    bus.s_ack_i = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Arbitration: simultaneous requests, IBus first, then round robin.
    @(negedge clk);
    drive_m(0, 1, 0, 0, 32'h0, 32'h0);
    drive_m(1, 1, 0, 0, 32'h0, 32'h0);
    @(negedge clk); #1;
    check("arb_first", 64'(grant), 64'b01);
    check("arb_busy", 64'(busy), 64'd1);
    @(negedge clk);
    drive_m(0, 0, 0, 0, 32'h0, 32'h0);
    #1 check("arb_rel_cyc", 64'(bus.s_cyc_o), 64'd0);
    @(negedge clk); #1;
    check("arb_gap", 64'(grant), 64'b00);
    @(negedge clk); #1;
    check("arb_idle", 64'(grant), 64'b00);
    @(negedge clk); #1;
    check("arb_dbus", 64'(grant), 64'b10);
    check("arb_dbus_cyc", 64'(bus.s_cyc_o), 64'd1);
    drive_m(1, 0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    drive_m(0, 1, 0, 0, 32'h0, 32'h0);
    drive_m(1, 1, 0, 0, 32'h0, 32'h0);
    #1 check("arb_gap2", 64'(grant), 64'b00);
    @(negedge clk); #1;
    check("arb_idle2", 64'(grant), 64'b00);
    @(negedge clk); #1;
    check("arb_rr_ibus", 64'(grant), 64'b01);
    drive_m(0, 0, 0, 0, 32'h0, 32'h0);
    drive_m(1, 0, 0, 0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);

    // IBus read from RAM, slave acks two cycles after strobe.
    drive_m(0, 1, 1, 0, 32'h1000_0004, 32'h0);
    slave_resp(1, 0, 32'hA5A5_0004);
    push_exp(2'b01, 2'b00, 32'hA5A5_0004);
    @(negedge clk); #1;
    check("rd_grant", 64'(grant), 64'b01);
    check("rd_stb", 64'(bus.s_stb_o), 64'(STB_RAM));
    check("rd_adr", 64'(bus.s_adr_o), 64'h1000_0004);
    check("rd_wait1", 64'(bus.m_ack_o), 64'd0);
    @(negedge clk); #1;
    check("rd_wait2", 64'(bus.m_ack_o), 64'd0);
    @(negedge clk);
    slave_resp(1, 1, 32'hA5A5_0004);
    #1 expect_resp("rd_ram");
    @(negedge clk);
    slave_resp(1, 0, 32'h0);
    drive_m(0, 0, 0, 0, 32'h0, 32'h0);
    #1 check("rd_ack_once", 64'(bus.m_ack_o), 64'd0);
    check("rd_rel_cyc", 64'(bus.s_cyc_o), 64'd0);
    repeat (2) @(negedge clk);

    // DBus write to unmapped space: error two cycles after strobe.
    drive_m(1, 1, 1, 1, 32'hF000_0000, 32'h1234);
    push_exp(2'b00, 2'b10, 32'h0);
    @(negedge clk); #1;
    check("um_grant", 64'(grant), 64'b10);
    check("um_stb", 64'(bus.s_stb_o), 64'd0);
    check("um_err_early", 64'(bus.m_err_o), 64'd0);
    @(negedge clk); #1;
    expect_resp("um");
    drive_m(1, 1, 0, 1, 32'hF000_0000, 32'h1234);
    @(negedge clk); #1;
    check("um_err_once", 64'(bus.m_err_o), 64'd0);
    check("um_grant_kept", 64'(grant), 64'b10);
    drive_m(1, 0, 0, 0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);

    // Watchdog: LED never answers, twice in one CYC.
    drive_m(0, 1, 1, 0, 32'h8000_0100, 32'h0);
    push_exp(2'b00, 2'b01, 32'h0);
    timeout_probe("to1");
    drive_m(0, 1, 0, 0, 32'h8000_0100, 32'h0);
    @(negedge clk); #1;
    check("to_err_once", 64'(bus.m_err_o), 64'd0);
    drive_m(0, 1, 1, 0, 32'h8000_0100, 32'h0);
    push_exp(2'b00, 2'b01, 32'h0);
    timeout_probe("to2");
    drive_m(0, 0, 0, 0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);

    // Block cycle: DBus performs 3 accesses while IBus waits.
    drive_m(1, 1, 1, 0, 32'h1000_0010, 32'h0);
    push_exp(2'b10, 2'b00, 32'hB000_0000);
    @(negedge clk); #1;
    check("blk_grant", 64'(grant), 64'b10);
    drive_m(0, 1, 1, 0, 32'h1000_0020, 32'h0);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      slave_resp(1, 1, 32'hB000_0000 + 32'(j));
      #1 expect_resp("blk_beat");
      check("blk_owner", 64'(grant), 64'b10);
      @(negedge clk);
      slave_resp(1, 0, 32'h0);
      drive_m(1, 1, 0, 0, 32'h1000_0010, 32'h0);
      #1 check("blk_ack_low", 64'(bus.m_ack_o), 64'd0);
      if (j < 2) begin
        @(negedge clk);
        drive_m(1, 1, 1, 0, 32'h1000_0014 + 32'(4 * j), 32'h0);
        push_exp(2'b10, 2'b00, 32'hB000_0001 + 32'(j));
      end
    end
    @(negedge clk);
    drive_m(1, 0, 0, 0, 32'h0, 32'h0);
    #1 check("blk_hold", 64'(grant), 64'b10);
    push_exp(2'b01, 2'b00, 32'hC0DE_0020);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      if (grant == 2'b01) break;
    end
    check("blk_ibus_grant", 64'(grant), 64'b01);
    check("blk_ibus_adr", 64'(bus.s_adr_o), 64'h1000_0020);
    @(negedge clk);
    slave_resp(1, 1, 32'hC0DE_0020);
    #1 expect_resp("blk_ibus");
    @(negedge clk);
    slave_resp(1, 0, 32'h0);
    drive_m(0, 0, 0, 0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);

    // Reset while a RAM access is outstanding; a late ack is dropped.
    drive_m(0, 1, 1, 0, 32'h1000_0008, 32'h0);
    @(negedge clk); #1;
    check("mr_pending", 64'(bus.s_stb_o), 64'(STB_RAM));
    #2 rst_n = 1'b0;
    #1;
    check("mr_grant", 64'(grant), 64'd0);
    check("mr_busy", 64'(busy), 64'd0);
    check("mr_cyc", 64'(bus.s_cyc_o), 64'd0);
    check("mr_stb", 64'(bus.s_stb_o), 64'd0);
    check("mr_adr", 64'(bus.s_adr_o), 64'd0);
    drive_m(0, 0, 0, 0, 32'h0, 32'h0);
    slave_resp(1, 1, 32'hDEAD_BEEF);
    #1 check("mr_ack", 64'(bus.m_ack_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("mr_late_ack", 64'(bus.m_ack_o), 64'd0);
    end
    slave_resp(1, 0, 32'h0);

    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
